// File: rtl/hub75_pkg.sv
// ----------------------------------------------------------------------------
// hub75_pkg
// Shared types and constants for the 64x64 HUB75 panel scan driver.
//   scanState_t  : scan FSM states (SHIFT -> BLANK -> LATCH -> DISPLAY)
//   PANEL_*      : panel geometry (64 columns, 32 scanned row pairs)
//   CH_BITS      : bits per colour channel in the ROM pixel word
//   R/G/B_OFS    : bit offsets of each channel inside {R,G,B}
//   pixelBits()  : picks one bit-plane bit from each channel of a pixel
// ----------------------------------------------------------------------------
package hub75_pkg;

    typedef enum logic [1:0] {
        SHIFT   = 2'd0,
        BLANK   = 2'd1,
        LATCH   = 2'd2,
        DISPLAY = 2'd3
    } scanState_t;

    localparam int PANEL_COLS   = 64;
    localparam int PANEL_ROWS   = 32;
    localparam int CH_BITS      = 8;

    localparam int R_OFS        = 16;
    localparam int G_OFS        = 8;
    localparam int B_OFS        = 0;

    // Two cycles per column plus two trailing cycles for the last column's
    // data/clock phases.
    localparam int SHIFT_CYCLES = 2 * PANEL_COLS + 2;

    // Returns {R,G,B} bit number bitIdx (0..7) of a 24-bit pixel. Shifting
    // first keeps all selects constant.
    function automatic logic [2:0] pixelBits(input logic [23:0] pix,
                                             input logic [2:0]  bitIdx);
        logic [23:0] sh;
        sh = pix >> bitIdx;
        return {sh[R_OFS], sh[G_OFS], sh[B_OFS]};
    endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// ----------------------------------------------------------------------------
// hub75_bcm_timer
// Loadable down-counter that times one DISPLAY (OE active) window of the
// binary-code-modulation scheme. Plane p lasts BASE_CYCLES<<p cycles.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   load_i   in   start a new window (asserted on the edge entering DISPLAY)
//   plane_i  in   bit plane being displayed, selects window length
//   done_o   out  high during the last cycle of the window
// ----------------------------------------------------------------------------
module hub75_bcm_timer #(
    parameter int PLANES      = 3,
    parameter int BASE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [2:0] plane_i,
    output logic       done_o
);

    // Sized for the longest window so the top plane never overflows.
    localparam int MAX_CYCLES = BASE_CYCLES << (PLANES - 1);
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic [CNT_W-1:0] loadVal;

    // Counter holds (cycles remaining - 1), so zero marks the final cycle.
    always_comb begin
        loadVal = CNT_W'((BASE_CYCLES << plane_i) - 1);
    end

    // Next-state: load wins, otherwise count down to zero and then go idle
    // so done_o is a single-cycle indication.
    always_comb begin
        cnt_d     = cnt_q;
        running_d = running_q;
        if (load_i) begin
            cnt_d     = loadVal;
            running_d = 1'b1;
        end else if (running_q) begin
            if (cnt_q == '0) begin
                running_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            running_q <= running_d;
        end
    end

    assign done_o = running_q && (cnt_q == '0);

endmodule

// File: rtl/hub75_scan.sv
// ----------------------------------------------------------------------------
// hub75_scan
// Continuous scan driver for a 64x64 1/32-scan HUB75 panel. Fetches two
// pixels per column from a 1-cycle-latency sprite ROM (upper and lower half),
// slices them into BCM bit planes and drives the panel shift/latch/OE/row pins.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   addrx, addry        ROM column / row address
//   data0, data1        upper / lower half pixel {R,G,B}, 1 clk after address
//   gp_r1..gp_b1        upper half colour bits
//   gp_r2..gp_b2        lower half colour bits
//   gp_clk              panel shift clock (panel samples on rising edge)
//   gp_lat              panel latch, active high
//   gp_oe_n             panel output enable, active low
//   gp_row              panel row select A..E
//   frame_start         1-cycle pulse on the first cycle of each frame
// ----------------------------------------------------------------------------
module hub75_scan
    import hub75_pkg::*;
#(
    parameter int PLANES       = 3,
    parameter int BASE_CYCLES  = 4,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [5:0]  addrx,
    output logic [4:0]  addry,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    output logic        gp_r1,
    output logic        gp_g1,
    output logic        gp_b1,
    output logic        gp_r2,
    output logic        gp_g2,
    output logic        gp_b2,
    output logic        gp_clk,
    output logic        gp_lat,
    output logic        gp_oe_n,
    output logic [4:0]  gp_row,
    output logic        frame_start
);

    localparam logic [7:0] SHIFT_LAST = 8'(SHIFT_CYCLES - 1);
    localparam logic [7:0] COL_END    = 8'(2 * PANEL_COLS);
    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);
    localparam logic [2:0] PLANE_LAST = 3'(PLANES - 1);
    localparam logic [2:0] PLANE_BASE = 3'(CH_BITS - PLANES);

    // FSM state. state_q/cnt_q describe the cycle the outputs are showing.
    scanState_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [4:0] row_q, row_d;
    logic [2:0] plane_q, plane_d;
    // Set by reset so the first edge after release produces SHIFT cycle 0.
    logic       restart_q;

    // Registered outputs.
    logic [5:0] addrx_q, addrx_d;
    logic [4:0] addry_q, addry_d;
    logic [5:0] rgb_q, rgb_d;
    logic       gpClk_q, gpClk_d;
    logic       gpLat_q, gpLat_d;
    logic       gpOeN_q, gpOeN_d;
    logic [4:0] gpRow_q, gpRow_d;
    logic       frameStart_q, frameStart_d;

    logic       timerLoad;
    logic       timerDone;
    logic [2:0] bitIdx;

    // Channel bit used by the current plane: the top PLANES bits of each
    // channel, plane 0 being the least significant of them.
    always_comb begin
        bitIdx = PLANE_BASE + plane_q;
    end

    // The DISPLAY window is timed by the BCM timer, started on entry.
    always_comb begin
        timerLoad = (state_d == DISPLAY) && (state_q != DISPLAY);
    end

    hub75_bcm_timer #(
        .PLANES      (PLANES),
        .BASE_CYCLES (BASE_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load_i  (timerLoad),
        .plane_i (plane_q),
        .done_o  (timerDone)
    );

    // State register plus output registers. Reset dominates, blanking the
    // panel immediately and parking the scan at row 0, plane 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= SHIFT;
            cnt_q        <= '0;
            row_q        <= '0;
            plane_q      <= '0;
            restart_q    <= 1'b1;
            addrx_q      <= '0;
            addry_q      <= '0;
            rgb_q        <= '0;
            gpClk_q      <= 1'b0;
            gpLat_q      <= 1'b0;
            gpOeN_q      <= 1'b1;
            gpRow_q      <= '0;
            frameStart_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            plane_q      <= plane_d;
            restart_q    <= 1'b0;
            addrx_q      <= addrx_d;
            addry_q      <= addry_d;
            rgb_q        <= rgb_d;
            gpClk_q      <= gpClk_d;
            gpLat_q      <= gpLat_d;
            gpOeN_q      <= gpOeN_d;
            gpRow_q      <= gpRow_d;
            frameStart_q <= frameStart_d;
        end
    end

    // Next-state logic. cnt counts cycles within SHIFT and BLANK; DISPLAY is
    // left to the timer. Plane advances every DISPLAY, row after the last
    // plane (5-bit row wraps 31 -> 0 naturally).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        row_d   = row_q;
        plane_d = plane_q;
        if (restart_q) begin
            state_d = SHIFT;
            cnt_d   = '0;
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q == SHIFT_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = LATCH;
                        cnt_d   = '0;
                    end
                end
                LATCH: begin
                    state_d = DISPLAY;
                    cnt_d   = '0;
                end
                DISPLAY: begin
                    cnt_d = '0;
                    if (timerDone) begin
                        state_d = SHIFT;
                        if (plane_q == PLANE_LAST) begin
                            plane_d = '0;
                            row_d   = row_q + 5'd1;
                        end else begin
                            plane_d = plane_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output logic, evaluated for the cycle being entered. Within SHIFT,
    // column k is addressed on cycles 2k/2k+1; its ROM word arrives one clock
    // later and is captured as the RGB outputs for cycles 2k+2/2k+3, with
    // gp_clk high on 2k+3 so data is settled a full cycle before the edge.
    // The column address holds at 63 for the two trailing cycles and returns
    // to 0 when SHIFT ends.
    always_comb begin
        addrx_d      = '0;
        addry_d      = row_d;
        rgb_d        = rgb_q;
        gpClk_d      = 1'b0;
        gpLat_d      = (state_d == LATCH);
        gpOeN_d      = (state_d != DISPLAY);
        gpRow_d      = gpRow_q;
        frameStart_d = 1'b0;
        if (state_d == SHIFT) begin
            addrx_d      = (cnt_d < COL_END) ? cnt_d[6:1] : addrx_q;
            gpClk_d      = cnt_d[0] && (cnt_d >= 8'd3);
            frameStart_d = (cnt_d == 8'd0) && (row_d == 5'd0) && (plane_d == 3'd0);
            if (!cnt_d[0] && (cnt_d >= 8'd2)) begin
                rgb_d = {pixelBits(data0, bitIdx), pixelBits(data1, bitIdx)};
            end
        end
        // Row select only moves on the first blanking cycle, while OE is off.
        if ((state_d == BLANK) && (state_q != BLANK)) begin
            gpRow_d = row_q;
        end
    end

    assign addrx       = addrx_q;
    assign addry       = addry_q;
    assign gp_r1       = rgb_q[5];
    assign gp_g1       = rgb_q[4];
    assign gp_b1       = rgb_q[3];
    assign gp_r2       = rgb_q[2];
    assign gp_g2       = rgb_q[1];
    assign gp_b2       = rgb_q[0];
    assign gp_clk      = gpClk_q;
    assign gp_lat      = gpLat_q;
    assign gp_oe_n     = gpOeN_q;
    assign gp_row      = gpRow_q;
    assign frame_start = frameStart_q;

endmodule

// File: tb/tb_hub75_scan.sv
// ----------------------------------------------------------------------------
// tb_hub75_scan
// Directed bench for hub75_scan (PLANES=3, BASE_CYCLES=4, BLANK_CYCLES=2)
// with a 1-clock-latency ROM model whose contents are chosen by romMode.
// ----------------------------------------------------------------------------
module tb_hub75_scan;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  addrx;
    logic [4:0]  addry;
    logic [23:0] data0 = '0;
    logic [23:0] data1 = '0;
    logic        gp_r1, gp_g1, gp_b1, gp_r2, gp_g2, gp_b2;
    logic        gp_clk, gp_lat, gp_oe_n;
    logic [4:0]  gp_row;
    logic        frame_start;
    logic [5:0]  rgb;

    int romMode = 0;
    int checks  = 0;
    int passes  = 0;
    int cyc     = 0;

    typedef struct {
        int         mode;
        int         c;
        logic [5:0] ax;
        logic [4:0] ay;
        logic       ck;
        logic       oe;
        logic       lt;
        logic [5:0] rgbE;
        logic       fs;
    } vec_t;

    vec_t vecs[$];

    assign rgb = {gp_r1, gp_g1, gp_b1, gp_r2, gp_g2, gp_b2};

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // ROM model: registered read, mode 0 is a constant colour pair,
    // mode 1 puts the column LSB into the upper-half red MSB only.
    always @(posedge clk) begin
        if (romMode == 0) begin
            data0 <= 24'hFF0000;
            data1 <= 24'h0000FF;
        end else begin
            data0 <= {addrx[0], 23'd0};
            data1 <= 24'd0;
        end
    end

    hub75_scan #(
        .PLANES       (3),
        .BASE_CYCLES  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addrx       (addrx),
        .addry       (addry),
        .data0       (data0),
        .data1       (data1),
        .gp_r1       (gp_r1),
        .gp_g1       (gp_g1),
        .gp_b1       (gp_b1),
        .gp_r2       (gp_r2),
        .gp_g2       (gp_g2),
        .gp_b2       (gp_b2),
        .gp_clk      (gp_clk),
        .gp_lat      (gp_lat),
        .gp_oe_n     (gp_oe_n),
        .gp_row      (gp_row),
        .frame_start (frame_start)
    );

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reset for 5 cycles with the given ROM contents, release, and step to
    // SHIFT cycle 0 of the first frame (cyc = 0).
    task automatic applyStimulus(input int mode);
        romMode = mode;
        reset   = 1'b1;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        cyc = 0;
    endtask

    function automatic vec_t mkVec(input int mode, input int c, input logic [5:0] ax,
                                   input logic [4:0] ay, input logic ck, input logic oe,
                                   input logic lt, input logic [5:0] rgbE, input logic fs);
        vec_t v;
        v.mode = mode; v.c = c; v.ax = ax; v.ay = ay; v.ck = ck;
        v.oe = oe; v.lt = lt; v.rgbE = rgbE; v.fs = fs;
        return v;
    endfunction

    initial begin
        int pulses, bad, lowRun, planeIdx, pulseIdx, changes, fsAt, latCount;
        logic       prevClk, prevLat;
        logic [5:0] prevRgb, expRgb;
        logic [4:0] prevRow;
        logic       found;
        int         runs[$];

        // Expected outputs per frame cycle; plane 0 SHIFT 0..129, BLANK
        // 130..131, LATCH 132, DISPLAY 133..136, plane 1 from 137 (DISPLAY
        // 270..277), plane 2 from 278 (DISPLAY 411..426), row 1 from 427.
        //                 mode cyc  ax  ay ck oe lt rgb        fs
        vecs.push_back(mkVec(0,   0,  0, 0, 0, 1, 0, 6'b000000, 1));
        vecs.push_back(mkVec(0,   1,  0, 0, 0, 1, 0, 6'b000000, 0));
        vecs.push_back(mkVec(0,   2,  1, 0, 0, 1, 0, 6'b100001, 0));
        vecs.push_back(mkVec(0,   3,  1, 0, 1, 1, 0, 6'b100001, 0));
        vecs.push_back(mkVec(0, 127, 63, 0, 1, 1, 0, 6'b100001, 0));
        vecs.push_back(mkVec(0, 129, 63, 0, 1, 1, 0, 6'b100001, 0));
        vecs.push_back(mkVec(0, 130,  0, 0, 0, 1, 0, 6'b100001, 0));
        vecs.push_back(mkVec(0, 132,  0, 0, 0, 1, 1, 6'b100001, 0));
        vecs.push_back(mkVec(0, 133,  0, 0, 0, 0, 0, 6'b100001, 0));
        vecs.push_back(mkVec(0, 136,  0, 0, 0, 0, 0, 6'b100001, 0));
        vecs.push_back(mkVec(0, 137,  0, 0, 0, 1, 0, 6'b100001, 0));
        vecs.push_back(mkVec(0, 277,  0, 0, 0, 0, 0, 6'b100001, 0));
        vecs.push_back(mkVec(0, 278,  0, 0, 0, 1, 0, 6'b100001, 0));
        vecs.push_back(mkVec(0, 426,  0, 0, 0, 0, 0, 6'b100001, 0));
        vecs.push_back(mkVec(0, 427,  0, 1, 0, 1, 0, 6'b100001, 0));
        vecs.push_back(mkVec(1,   4,  2, 0, 0, 1, 0, 6'b000000, 0));
        vecs.push_back(mkVec(1, 141,  2, 0, 0, 1, 0, 6'b000000, 0));
        vecs.push_back(mkVec(1, 280,  1, 0, 0, 1, 0, 6'b000000, 0));
        vecs.push_back(mkVec(1, 282,  2, 0, 0, 1, 0, 6'b100000, 0));
        vecs.push_back(mkVec(1, 283,  2, 0, 1, 1, 0, 6'b100000, 0));
        vecs.push_back(mkVec(1, 285,  3, 0, 1, 1, 0, 6'b000000, 0));

        // Reset state and first cycle after release.
        romMode = 0;
        reset   = 1'b1;
        repeat (5) tick();
        checkOutput("resetState", 32'({gp_oe_n, gp_lat, gp_clk, rgb, frame_start}),
                    32'({1'b1, 1'b0, 1'b0, 6'b000000, 1'b0}));
        reset = 1'b0;
        tick();
        checkOutput("firstCycle", 32'({frame_start, addrx, addry}),
                    32'({1'b1, 6'd0, 5'd0}));

        // Table-driven vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].mode);
            while (cyc < vecs[i].c) tick();
            checkOutput($sformatf("vec%0d_cyc%0d", i, vecs[i].c),
                        32'({addrx, addry, gp_clk, gp_oe_n, gp_lat, rgb, frame_start}),
                        32'({vecs[i].ax, vecs[i].ay, vecs[i].ck, vecs[i].oe, vecs[i].lt,
                             vecs[i].rgbE, vecs[i].fs}));
        end

        // Constant colour: 64 shift pulses, RGB settled before and during each.
        applyStimulus(0);
        pulses = 0; bad = 0; prevClk = gp_clk; prevRgb = rgb;
        for (int n = 0; n < 136; n++) begin
            tick();
            if (gp_clk && !prevClk) begin
                pulses++;
                if (rgb !== 6'b100001 || prevRgb !== 6'b100001) bad++;
            end
            prevClk = gp_clk; prevRgb = rgb;
        end
        checkOutput("constPulses", 32'(pulses), 32'd64);
        checkOutput("constRgbBad", 32'(bad), 32'd0);

        // Column-parity pattern: only plane 2 carries data, r1 = column LSB.
        applyStimulus(1);
        pulses = 0; bad = 0; planeIdx = 0; pulseIdx = 0;
        prevClk = gp_clk; prevRgb = rgb;
        for (int n = 0; n < 426; n++) begin
            tick();
            if (gp_lat) begin
                planeIdx++;
                pulseIdx = 0;
            end
            if (gp_clk && !prevClk) begin
                expRgb = (planeIdx == 2 && (pulseIdx % 2) == 1) ? 6'b100000 : 6'b000000;
                if (rgb !== expRgb || prevRgb !== expRgb) bad++;
                pulses++;
                pulseIdx++;
            end
            prevClk = gp_clk; prevRgb = rgb;
        end
        checkOutput("parityPulses", 32'(pulses), 32'd192);
        checkOutput("parityBad", 32'(bad), 32'd0);

        // OE-low run lengths and latch pulse shape over one row.
        applyStimulus(0);
        lowRun = 0; bad = 0; latCount = 0; prevLat = 1'b0;
        for (int n = 0; n < 430; n++) begin
            tick();
            if (!gp_oe_n) begin
                lowRun++;
            end else begin
                if (lowRun != 0) runs.push_back(lowRun);
                lowRun = 0;
            end
            if (gp_lat) begin
                latCount++;
                if (!gp_oe_n || prevLat) bad++;
            end
            prevLat = gp_lat;
        end
        checkOutput("oeRun0", 32'(runs.size() > 0 ? runs[0] : -1), 32'd4);
        checkOutput("oeRun1", 32'(runs.size() > 1 ? runs[1] : -1), 32'd8);
        checkOutput("oeRun2", 32'(runs.size() > 2 ? runs[2] : -1), 32'd16);
        checkOutput("latCount", 32'(latCount), 32'd3);
        checkOutput("latShapeBad", 32'(bad), 32'd0);

        // Full frame: row select steps 0..31 and wraps, only while blanked;
        // frame_start repeats after 32*(3*133+28) cycles.
        applyStimulus(0);
        prevRow = gp_row; changes = 0; bad = 0; fsAt = -1;
        for (int n = 0; n < 13664 + 200; n++) begin
            tick();
            if (frame_start && fsAt < 0) fsAt = cyc;
            if (gp_row !== prevRow) begin
                changes++;
                if (!gp_oe_n || gp_row !== prevRow + 5'd1) bad++;
            end
            prevRow = gp_row;
        end
        checkOutput("rowChanges", 32'(changes), 32'd32);
        checkOutput("rowStepBad", 32'(bad), 32'd0);
        checkOutput("framePeriod", 32'(fsAt), 32'd13664);

        // Reset in the 3rd DISPLAY cycle of row 5.
        applyStimulus(0);
        lowRun = 0; found = 1'b0;
        for (int n = 0; n < 3000 && !found; n++) begin
            tick();
            lowRun = gp_oe_n ? 0 : lowRun + 1;
            if (gp_row == 5'd5 && lowRun == 3) found = 1'b1;
        end
        checkOutput("row5DisplayFound", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("midResetBlank", 32'({gp_oe_n, gp_lat}), 32'({1'b1, 1'b0}));
        tick();
        reset = 1'b0;
        tick();
        checkOutput("restartState", 32'({frame_start, addrx, addry, gp_row, gp_oe_n}),
                    32'({1'b1, 6'd0, 5'd0, 5'd0, 1'b1}));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/hub75_scan.md
Name: hub75_scan

Overview:
- Panel scan driver for the 64x64 HUB75 LED panel (1/32 scan, two half-panels driven in parallel).
- Sits directly downstream of the two-port sprite ROM. It generates the ROM column/row addresses and consumes the two 24-bit RGB pixels returned, one per half-panel.
- Converts pixels to binary-code-modulated (BCM) bit planes and drives panel shift clock, latch, output-enable and row-select pins.

Parameters:
- PLANES, 3: number of BCM bit planes used per colour channel (1..8). Uses the top PLANES bits of each 8-bit channel.
- BASE_CYCLES, 4: OE-active cycles for plane 0. Plane p is active for BASE_CYCLES<<p cycles.
- BLANK_CYCLES, 2: OE-inactive cycles before the latch. The row address changes during this window.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- addrx  out  6  ROM column address (0..63).
- addry  out  5  ROM row address (0..31).
- data0  in  24  upper half pixel, {R[7:0],G[7:0],B[7:0]}; valid 1 clk after addrx/addry.
- data1  in  24  lower half pixel, same format and latency.
- gp_r1, gp_g1, gp_b1  out  1 each  upper half colour bits.
- gp_r2, gp_g2, gp_b2  out  1 each  lower half colour bits.
- gp_clk  out  1  panel shift clock; the panel samples on the rising edge.
- gp_lat  out  1  panel latch, active high.
- gp_oe_n  out  1  panel output enable, active low.
- gp_row  out  5  panel row select A..E.
- frame_start  out  1  1-cycle pulse at the start of each frame.

Behaviour:
- All outputs are registered.
- Reset values: addrx=0, addry=0, all RGB outputs=0, gp_clk=0, gp_lat=0, gp_oe_n=1, gp_row=0, frame_start=0. FSM goes to SHIFT, row=0, plane=0.
- Reset is synchronous and dominates everything. If asserted mid-operation (any state), gp_oe_n=1 and gp_lat=0 on the next edge, and the scan restarts from row 0, plane 0.
- FSM states: SHIFT -> BLANK -> LATCH -> DISPLAY -> SHIFT. There is no idle state; scanning runs continuously.
- SHIFT (130 cycles, counted from state entry at cycle 0):
  - addrx=k is presented during cycles 2k and 2k+1, k=0..63.
  - ROM data for column k is sampled at the end of cycle 2k+1.
  - RGB outputs are driven during cycles 2k+2 and 2k+3.
  - gp_clk is high only during cycle 2k+3.
  - Exactly 64 gp_clk pulses per SHIFT. RGB is stable 1 cycle before the rising edge and throughout the high phase.
  - gp_oe_n=1 throughout SHIFT (display is blanked while shifting).
- Colour bit for plane p is bit (8-PLANES+p) of each channel: R=data[16+i], G=data[8+i], B=data[i], where i=8-PLANES+p.
- BLANK (BLANK_CYCLES cycles): gp_oe_n=1, gp_clk=0. gp_row is loaded with the current row on the first cycle.
- LATCH (1 cycle): gp_lat=1 and gp_oe_n=1. gp_lat=0 in every other state.
- DISPLAY (BASE_CYCLES<<plane cycles): gp_oe_n=0.
- Exit from DISPLAY:
  - plane<PLANES-1: plane++, same row.
  - otherwise plane=0 and row++; row wraps 31->0.
- addry = current row for the whole SHIFT.
- frame_start=1 for the first cycle of SHIFT when row=0 and plane=0, including the first SHIFT after reset.
- Frame length in cycles = 32 * sum over p of (130 + BLANK_CYCLES + 1 + (BASE_CYCLES<<p)).
- The duration counter is wide enough for BASE_CYCLES<<(PLANES-1) with no overflow. The column counter wraps only at SHIFT exit.

Decomposition:
- Package hub75_pkg:
  - FSM state enum {SHIFT, BLANK, LATCH, DISPLAY}.
  - Constants PANEL_COLS=64, PANEL_ROWS=32, CH_BITS=8.
  - Channel bit offsets R=16, G=8, B=0.
- Sub-module hub75_bcm_timer:
  - Loadable down-counter.
  - Inputs: load, plane.
  - Output: done, asserted on the last DISPLAY cycle.

Test Plan:
- Reset held 5 cycles, then released -> during reset gp_oe_n=1, gp_lat=0, gp_clk=0, RGB=0. First cycle after release: frame_start=1, addrx=0, addry=0.
- ROM model with 1-clk latency returning data0=24'hFF0000 and data1=24'h0000FF for every address -> 64 gp_clk pulses per SHIFT, with gp_r1=1, gp_b2=1 and all other colour outputs 0 at every rising gp_clk.
- ROM model with data0 bit 23 = addrx[0] (R channel MSB only), PLANES=3 -> planes 0 and 1 shift all zeros. Plane 2 shifts r1 = 0,1,0,1,... aligned to columns 0..63, proving the 1-cycle latency alignment.
- PLANES=3, BASE_CYCLES=4 -> gp_oe_n low for exactly 4, 8, 16 consecutive cycles in successive DISPLAYs. gp_lat pulses exactly 1 cycle each, always with gp_oe_n=1 at the same time.
- Run a full frame -> gp_row steps 0..31 then wraps to 0, changing only while gp_oe_n=1. frame_start pulses again exactly 32*(3*133+28)=13664 cycles after the previous pulse.
- Assert reset in the 3rd cycle of a DISPLAY with row=5 -> next cycle gp_oe_n=1. After release, the scan restarts at row 0, plane 0 with frame_start=1.
